// File: rtl/shift_sequencer.sv
// ============================================================================
// Module      : shift_sequencer
// Description : Iterative 32-bit shifter (SLL / SRA / optional SRL), one bit
//               position per cycle. Define SHIFT_SEQUENCER_SRL_EN to compile
//               in the logical right shift on op 2'b10.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_start,
    input  logic [1:0]       ctrl_op,
    input  logic [4:0]       ctrl_shiftamt,
    input  logic [WIDTH-1:0] data_operandA,
    output logic             ctrl_ready,
    output logic [WIDTH-1:0] data_result,
    output logic             data_resultRDY,
    output logic             data_exception
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRA = 2'b01;
`ifdef SHIFT_SEQUENCER_SRL_EN
    localparam logic [1:0] OP_SRL = 2'b10;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q,  work_d;
    logic [4:0]       cnt_q,   cnt_d;
    logic [1:0]       op_q,    op_d;

    logic             start_illegal;
    logic             held_illegal;
    logic [WIDTH-1:0] step_value;

    function automatic logic op_is_illegal(input logic [1:0] op);
`ifdef SHIFT_SEQUENCER_SRL_EN
        return (op == 2'b11);
`else
        return op[1];
`endif
    endfunction

    assign start_illegal = op_is_illegal(ctrl_op);
    assign held_illegal  = op_is_illegal(op_q);

    // One-bit step of the latched operation; illegal ops never reach SHIFT.
    always_comb begin
        step_value = work_q;
        case (op_q)
            OP_SLL:  step_value = {work_q[WIDTH-2:0], 1'b0};
            OP_SRA:  step_value = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
`ifdef SHIFT_SEQUENCER_SRL_EN
            OP_SRL:  step_value = {1'b0, work_q[WIDTH-1:1]};
`endif
            default: step_value = work_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        case (state_q)
            IDLE, DONE: begin
                if (ctrl_start) begin
                    work_d = data_operandA;
                    op_d   = ctrl_op;
                    cnt_d  = ctrl_shiftamt;
                    if (start_illegal || (ctrl_shiftamt == 5'd0)) begin
                        state_d = DONE;
                    end else begin
                        state_d = SHIFT;
                    end
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                work_d = step_value;
                cnt_d  = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= 5'd0;
            op_q    <= OP_SLL;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end

    assign ctrl_ready     = (state_q == IDLE) || (state_q == DONE);
    assign data_result    = work_q;
    assign data_resultRDY = (state_q == DONE);
    assign data_exception = (state_q == DONE) && held_illegal;

endmodule

`default_nettype wire

// File: tb/tb_shift_sequencer.sv
// ============================================================================
// Module      : tb_shift_sequencer
// Description : Self-checking bench for shift_sequencer: directed cases plus
//               randomized operations against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ctrl_start = 1'b0;
    logic [1:0]  ctrl_op = 2'b00;
    logic [4:0]  ctrl_shiftamt = 5'd0;
    logic [31:0] data_operandA = 32'd0;
    logic        ctrl_ready;
    logic [31:0] data_result;
    logic        data_resultRDY;
    logic        data_exception;

    int n_checks = 0;
    int n_pass   = 0;

    shift_sequencer #(.WIDTH(32)) u_dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_start     (ctrl_start),
        .ctrl_op        (ctrl_op),
        .ctrl_shiftamt  (ctrl_shiftamt),
        .data_operandA  (data_operandA),
        .ctrl_ready     (ctrl_ready),
        .data_result    (data_result),
        .data_resultRDY (data_resultRDY),
        .data_exception (data_exception)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    endtask

    function automatic bit op_legal(input logic [1:0] op);
`ifdef SHIFT_SEQUENCER_SRL_EN
        return (op != 2'b11);
`else
        return (op[1] == 1'b0);
`endif
    endfunction

    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [4:0] s);
        if (!op_legal(op)) return a;
        case (op)
            2'b00:   return a << s;
            2'b01:   return $unsigned($signed(a) >>> s);
            default: return a >> s;
        endcase
    endfunction

    // Called at a negedge; leaves the bench at the negedge where RDY is seen.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [4:0] s,
                         input bit garble, input int pulse_at);
        int          n;
        logic [31:0] exp_res;
        int          exp_lat;
        exp_res = ref_result(op, a, s);
        exp_lat = op_legal(op) ? int'(s) + 1 : 1;
        ctrl_start    = 1'b1;
        ctrl_op       = op;
        ctrl_shiftamt = s;
        data_operandA = a;
        @(negedge clock);
        n = 1;
        ctrl_start = 1'b0;
        while (!data_resultRDY && n < 100) begin
            check("busy_ready", 32'(ctrl_ready), 32'd0);
            check("busy_exception", 32'(data_exception), 32'd0);
            ctrl_start = 1'b0;
            if (garble) begin
                ctrl_start    = 1'($urandom_range(0, 1));
                ctrl_op       = 2'($urandom);
                ctrl_shiftamt = 5'($urandom);
                data_operandA = $urandom;
            end
            if (n == pulse_at) begin
                ctrl_start    = 1'b1;
                data_operandA = 32'hFFFF_FFFF;
            end
            @(negedge clock);
            n++;
        end
        ctrl_start = 1'b0;
        check("latency", 32'(n), 32'(exp_lat));
        check("result", data_result, exp_res);
        check("exception", 32'(data_exception), 32'(!op_legal(op)));
        check("done_ready", 32'(ctrl_ready), 32'd1);
    endtask

    task automatic idle_gap();
        logic [31:0] held;
        held = data_result;
        ctrl_start = 1'b0;
        @(negedge clock);
        check("idle_rdy", 32'(data_resultRDY), 32'd0);
        check("idle_hold", data_result, held);
        check("idle_exception", 32'(data_exception), 32'd0);
        check("idle_ready", 32'(ctrl_ready), 32'd1);
    endtask

    initial begin
        int pulses;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        ctrl_start = 1'b1;
        @(negedge clock);
        check("rst_ready", 32'(ctrl_ready), 32'd1);
        check("rst_result", data_result, 32'd0);
        check("rst_rdy", 32'(data_resultRDY), 32'd0);
        check("rst_exception", 32'(data_exception), 32'd0);
        ctrl_start = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_ready", 32'(ctrl_ready), 32'd1);
        check("post_rst_rdy", 32'(data_resultRDY), 32'd0);

        do_op(2'b01, 32'h8000_0000, 5'd4, 1'b0, 0);
        check("sra_value", data_result, 32'hF800_0000);
        idle_gap();
        do_op(2'b00, 32'h0000_0001, 5'd31, 1'b0, 0);
        check("sll31_value", data_result, 32'h8000_0000);
        idle_gap();
        do_op(2'b00, 32'h1234_5678, 5'd0, 1'b0, 0);
        idle_gap();

        // Mid-flight start ignored, then a back-to-back accept from DONE.
        do_op(2'b01, 32'h0000_FF00, 5'd8, 1'b0, 3);
        check("ignored_start_value", data_result, 32'h0000_00FF);
        do_op(2'b00, 32'h0000_00F0, 5'd4, 1'b0, 0);
        check("b2b_value", data_result, 32'h0000_0F00);
        idle_gap();

        do_op(2'b10, 32'h8000_0000, 5'd4, 1'b0, 0);
        idle_gap();
        do_op(2'b11, 32'hDEAD_BEEF, 5'd17, 1'b0, 0);
        idle_gap();

        // Reset while shifting aborts without a result pulse.
        ctrl_start    = 1'b1;
        ctrl_op       = 2'b00;
        ctrl_shiftamt = 5'd20;
        data_operandA = 32'hA5A5_0001;
        @(negedge clock);
        ctrl_start = 1'b0;
        pulses = 0;
        repeat (5) begin
            if (data_resultRDY) pulses++;
            @(negedge clock);
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort_ready", 32'(ctrl_ready), 32'd1);
        check("abort_result", data_result, 32'd0);
        check("abort_exception", 32'(data_exception), 32'd0);
        repeat (25) begin
            if (data_resultRDY) pulses++;
            @(negedge clock);
        end
        check("abort_no_pulse", 32'(pulses), 32'd0);

        for (int i = 0; i < 40; i++) begin
            logic [4:0] s;
            case ($urandom_range(0, 4))
                0:       s = 5'd0;
                1:       s = 5'd31;
                default: s = 5'($urandom);
            endcase
            do_op(2'($urandom), $urandom, s, 1'b1, 0);
            if ($urandom_range(0, 1) == 0) idle_gap();
        end
        idle_gap();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
